// File: rtl/ppu_pixel_fifo.sv
// Background pixel FIFO for the PPU draw path.
// Takes one whole tile row (BPP bitplanes x TILE_W pixels) per accepted load.
// Drops a programmable number of leading pixels after each flush (fine scroll).
// Emits at most one pixel per cycle through a single registered output stage.
// The palette lookup (PAL_EN=1) assumes BPP==2: colour c maps to palette_i[2c+1:2c].
module ppu_pixel_fifo #(
  parameter int DEPTH  = 16,
  parameter int TILE_W = 8,
  parameter int BPP    = 2,
  parameter bit PAL_EN = 1'b1,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  flush_i,
  input  logic [2:0]            discard_i,
  input  logic                  load_valid_i,
  output logic                  load_ready_o,
  input  logic [BPP*TILE_W-1:0] planes_i,
  input  logic                  pop_en_i,
  input  logic [7:0]            palette_i,
  output logic [BPP-1:0]        px_out_o,
  output logic                  px_valid_o,
  output logic                  underflow_o,
  output logic [CW-1:0]         count_o
);

  logic [BPP-1:0] mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2:0]     discard_left_q, discard_left_d;
  logic [BPP-1:0] px_out_q, px_out_d;
  logic           px_valid_q, px_valid_d;
  logic           underflow_q, underflow_d;

  logic [BPP-1:0] row_pix [TILE_W];
  logic [BPP-1:0] rd_data;
  logic [BPP-1:0] px_mapped;
  logic           load;
  logic           pop_ok;
  logic           disc_pop;
  logic           out_pop;
  logic           pop;

  // Readiness looks only at registered occupancy; a same-cycle pop does not help.
  assign load_ready_o = !flush_i && (count_q <= CW'(DEPTH - TILE_W));
  assign load         = load_valid_i && load_ready_o;

  // Unpack the bitplanes into per-pixel colour indices, pixel 0 = leftmost (plane MSB).
  always_comb begin
    row_pix = '{default: '0};
    for (int i = 0; i < TILE_W; i++) begin
      for (int k = 0; k < BPP; k++) begin
        row_pix[i][k] = planes_i[k*TILE_W + TILE_W - 1 - i];
      end
    end
  end

  assign rd_data = mem_q[rd_ptr_q];

  generate
    if (PAL_EN) begin : g_pal
      logic [2:0] pal_idx;
      assign pal_idx   = {rd_data[1:0], 1'b0};
      assign px_mapped = palette_i[pal_idx +: 2];
    end else begin : g_raw
      assign px_mapped = rd_data;
    end
  endgenerate

  // Next-state: flush dominates, otherwise load and pop update pointers/count independently.
  always_comb begin
    pop_ok         = !flush_i && (count_q != '0);
    disc_pop       = pop_ok && (discard_left_q != '0);
    out_pop        = pop_ok && (discard_left_q == '0) && pop_en_i;
    pop            = disc_pop || out_pop;

    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    discard_left_d = discard_left_q;
    px_valid_d     = out_pop;
    px_out_d       = out_pop ? px_mapped : px_out_q;
    // An empty FIFO with discard pending is a legitimate wait, not an underflow.
    underflow_d    = !flush_i && (count_q == '0) && (discard_left_q == '0) && pop_en_i;

    if (flush_i) begin
      wr_ptr_d       = '0;
      rd_ptr_d       = '0;
      count_d        = '0;
      discard_left_d = discard_i;
    end else begin
      if (load) wr_ptr_d = wr_ptr_q + AW'(TILE_W);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + (load ? CW'(TILE_W) : '0) - (pop ? CW'(1) : '0);
      if (disc_pop) discard_left_d = discard_left_q - 3'd1;
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      discard_left_q <= '0;
      px_out_q       <= '0;
      px_valid_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      discard_left_q <= discard_left_d;
      px_out_q       <= px_out_d;
      px_valid_q     <= px_valid_d;
      underflow_q    <= underflow_d;
    end
  end

  // Pixel storage: a whole row lands at wr_ptr..wr_ptr+TILE_W-1, wrapping modulo DEPTH.
  always_ff @(posedge clk_i) begin
    if (rst_n_i && load) begin
      for (int i = 0; i < TILE_W; i++) begin
        mem_q[wr_ptr_q + AW'(i)] <= row_pix[i];
      end
    end
  end

  assign px_out_o    = px_out_q;
  assign px_valid_o  = px_valid_q;
  assign underflow_o = underflow_q;
  assign count_o     = count_q;

endmodule

// File: tb/tb_ppu_pixel_fifo.sv
// Directed bench for ppu_pixel_fifo: one raw-index instance and one palette instance share stimulus.
module tb_ppu_pixel_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  discard = 3'd0;
  logic        load_valid = 1'b0;
  logic [15:0] planes = 16'h0;
  logic        pop_en = 1'b0;
  logic [7:0]  palette = 8'hE4;

  logic        ready_a, valid_a, uf_a;
  logic [1:0]  px_a;
  logic [4:0]  cnt_a;
  logic        ready_b, valid_b, uf_b;
  logic [1:0]  px_b;
  logic [4:0]  cnt_b;

  int tests = 0;
  int fails = 0;

  logic [1:0] q [$];
  int         row_idx = 0;
  int         loads = 0;

  logic [1:0] exp_t2  [8] = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
  logic [1:0] exp_raw [8] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [1:0] exp_1b  [8] = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3};

  ppu_pixel_fifo #(.DEPTH(16), .TILE_W(8), .BPP(2), .PAL_EN(1'b0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .discard_i(discard),
    .load_valid_i(load_valid), .load_ready_o(ready_a), .planes_i(planes),
    .pop_en_i(pop_en), .palette_i(palette), .px_out_o(px_a),
    .px_valid_o(valid_a), .underflow_o(uf_a), .count_o(cnt_a)
  );

  ppu_pixel_fifo #(.DEPTH(16), .TILE_W(8), .BPP(2), .PAL_EN(1'b1)) dut_pal (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .discard_i(discard),
    .load_valid_i(load_valid), .load_ready_o(ready_b), .planes_i(planes),
    .pop_en_i(pop_en), .palette_i(palette), .px_out_o(px_b),
    .px_valid_o(valid_b), .underflow_o(uf_b), .count_o(cnt_b)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] row_planes(input int r);
    logic [7:0] lo, hi;
    lo = 8'(r * 37 + 5);
    hi = 8'(r * 91 + 3);
    return {hi, lo};
  endfunction

  // One cycle of the wrap test against a queue model of the FIFO contents.
  task automatic mcycle(input bit lv, input bit pe);
    bit         exp_rdy, do_load, do_pop;
    logic [1:0] e;
    logic [15:0] p;
    e = 2'd0;
    p = row_planes(row_idx);
    planes = p;
    load_valid = lv;
    pop_en = pe;
    exp_rdy = (q.size() <= 8);
    #0;
    chk("t4_ready", 32'(ready_a), 32'(exp_rdy));
    do_load = lv && exp_rdy;
    do_pop  = pe && (q.size() > 0);
    if (do_pop) e = q.pop_front();
    if (do_load) begin
      for (int i = 0; i < 8; i++) q.push_back({p[8 + 7 - i], p[7 - i]});
      loads++;
      row_idx++;
    end
    step();
    chk("t4_valid", 32'(valid_a), 32'(do_pop));
    if (do_pop) chk("t4_px", 32'(px_a), 32'(e));
    chk("t4_count", 32'(cnt_a), 32'(q.size()));
  endtask

  initial begin
    // T1 reset
    rst_n = 1'b0;
    step();
    step();
    chk("t1_count", 32'(cnt_a), 32'd0);
    chk("t1_valid", 32'(valid_a), 32'd0);
    chk("t1_ready", 32'(ready_a), 32'd1);
    chk("t1_underflow", 32'(uf_a), 32'd0);
    rst_n = 1'b1;

    // T2 basic pixel order
    flush = 1'b1; discard = 3'd0;
    step();
    flush = 1'b0;
    chk("t2_flush_count", 32'(cnt_a), 32'd0);
    load_valid = 1'b1; planes = {8'hCC, 8'hF0};
    step();
    load_valid = 1'b0;
    chk("t2_load_count", 32'(cnt_a), 32'd8);
    pop_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t2_valid", 32'(valid_a), 32'd1);
      chk("t2_px", 32'(px_a), 32'(exp_t2[i]));
      chk("t2_px_pal_e4", 32'(px_b), 32'(exp_t2[i]));
    end
    chk("t2_end_count", 32'(cnt_a), 32'd0);
    pop_en = 1'b0;
    step();
    chk("t2_idle_valid", 32'(valid_a), 32'd0);
    chk("t2_hold_px", 32'(px_a), 32'd0);

    // T3 fine scroll discard
    flush = 1'b1; discard = 3'd3;
    step();
    flush = 1'b0;
    load_valid = 1'b1; planes = {8'h00, 8'hFF}; pop_en = 1'b1;
    step();
    load_valid = 1'b0;
    chk("t3_load_count", 32'(cnt_a), 32'd8);
    chk("t3_no_underflow", 32'(uf_a), 32'd0);
    chk("t3_load_valid", 32'(valid_a), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_drop_valid", 32'(valid_a), 32'd0);
      chk("t3_drop_count", 32'(cnt_a), 32'(7 - i));
    end
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_valid", 32'(valid_a), 32'd1);
      chk("t3_px", 32'(px_a), 32'd1);
    end
    chk("t3_end_count", 32'(cnt_a), 32'd0);
    pop_en = 1'b0;
    step();

    // T4 full, stall and pointer wrap
    flush = 1'b1; discard = 3'd0;
    step();
    flush = 1'b0;
    mcycle(1'b1, 1'b0);
    mcycle(1'b1, 1'b0);
    chk("t4_full_count", 32'(cnt_a), 32'd16);
    chk("t4_full_ready", 32'(ready_a), 32'd0);
    for (int c = 0; c < 300 && loads < 20; c++) mcycle(1'b1, 1'b1);
    for (int c = 0; c < 40 && q.size() > 0; c++) mcycle(1'b0, 1'b1);
    chk("t4_loads", 32'(loads), 32'd20);
    chk("t4_drained", 32'(cnt_a), 32'd0);
    load_valid = 1'b0; pop_en = 1'b0;
    step();

    // T5 simultaneous load+pop, then flush beats load
    flush = 1'b1; discard = 3'd0;
    step();
    flush = 1'b0;
    load_valid = 1'b1; planes = {8'hCC, 8'hF0};
    step();
    chk("t5_count8", 32'(cnt_a), 32'd8);
    pop_en = 1'b1;
    step();
    chk("t5_count15", 32'(cnt_a), 32'd15);
    chk("t5_px", 32'(px_a), 32'd3);
    chk("t5_valid", 32'(valid_a), 32'd1);
    flush = 1'b1;
    #0;
    chk("t5_flush_ready", 32'(ready_a), 32'd0);
    step();
    chk("t5_flush_count", 32'(cnt_a), 32'd0);
    chk("t5_flush_valid", 32'(valid_a), 32'd0);
    flush = 1'b0; load_valid = 1'b0; pop_en = 1'b0;
    step();
    chk("t5_after_count", 32'(cnt_a), 32'd0);

    // T6 palette mapping and underflow
    palette = 8'hE4;
    load_valid = 1'b1; planes = {8'h30, 8'h50};
    step();
    load_valid = 1'b0;
    pop_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_e4_pal", 32'(px_b), 32'(exp_raw[i]));
      chk("t6_e4_raw", 32'(px_a), 32'(exp_raw[i]));
    end
    pop_en = 1'b0;
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    palette = 8'h1B;
    pop_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("t6_1b_pal", 32'(px_b), 32'(exp_1b[i]));
      chk("t6_1b_raw", 32'(px_a), 32'(exp_raw[i]));
      chk("t6_1b_valid", 32'(valid_b), 32'd1);
    end
    step();
    chk("t6_underflow", 32'(uf_a), 32'd1);
    chk("t6_underflow_pal", 32'(uf_b), 32'd1);
    chk("t6_uf_valid", 32'(valid_a), 32'd0);
    chk("t6_uf_count", 32'(cnt_a), 32'd0);
    pop_en = 1'b0;
    step();
    chk("t6_underflow_clear", 32'(uf_a), 32'd0);

    // Reset mid-line drops the buffered row
    load_valid = 1'b1; planes = {8'hCC, 8'hF0};
    step();
    load_valid = 1'b0;
    chk("rst_pre_count", 32'(cnt_a), 32'd8);
    pop_en = 1'b1;
    rst_n = 1'b0;
    step();
    pop_en = 1'b0;
    chk("rst_count", 32'(cnt_a), 32'd0);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_px", 32'(px_a), 32'd0);
    rst_n = 1'b1;
    step();
    chk("rst_ready", 32'(ready_a), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
